exec_cc_stage: RTL and testbench

- Execute-stage back end of the 64-bit ALU path. It consumes the operands, function code and result of the combinational ALU ops (add/sub/and/xor).
- It derives ZF/SF/OF, holds them in the condition-code register, evaluates the jXX/cmovXX condition, and registers valE/Cnd toward the memory stage.
- It sits between the ALU ops and the E/M pipeline register, under pipeline-control stall/bubble.

---
 rtl/exec_cc_stage.sv | 122 ++++++++++++
 tb/tb_exec_cc_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/exec_cc_stage.sv
// Execute-stage back end: derives ZF/SF/OF from the ALU result and holds them in the
// condition-code register. Evaluates the jXX/cmovXX condition and registers valE/cnd for memory.
module exec_cc_stage #(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] aluA,
    input  logic [W-1:0] aluB,
    input  logic [1:0]   alu_fun,
    input  logic [W-1:0] alu_out,
    input  logic         set_cc,
    input  logic         suppress_cc,
    input  logic [2:0]   cond_fun,
    input  logic         stall,
    input  logic         bubble,
    output logic         out_valid,
    output logic [W-1:0] valE,
    output logic         cnd,
    output logic [2:0]   cc
);

    localparam logic [1:0] FUN_ADD = 2'd0;
    localparam logic [1:0] FUN_SUB = 2'd1;

    localparam logic [2:0] C_ALWAYS = 3'd0;
    localparam logic [2:0] C_LE     = 3'd1;
    localparam logic [2:0] C_L      = 3'd2;
    localparam logic [2:0] C_E      = 3'd3;
    localparam logic [2:0] C_NE     = 3'd4;
    localparam logic [2:0] C_GE     = 3'd5;
    localparam logic [2:0] C_G      = 3'd6;

    logic [2:0]   cc_reg;
    logic [2:0]   cc_next;
    logic         out_valid_reg;
    logic [W-1:0] val_e_reg;
    logic         cnd_reg;

    logic         sign_a;
    logic         sign_b;
    logic         sign_r;
    logic         zf_next;
    logic         sf_next;
    logic         of_next;
    logic         cc_load;
    logic         zf_cur;
    logic         sf_cur;
    logic         of_cur;
    logic         cond_true;

    // Only the operand sign bits feed overflow detection.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{aluA[W-2:0], aluB[W-2:0]};

    // Flag derivation from the trusted ALU result.
    always_comb begin
        sign_a  = aluA[W-1];
        sign_b  = aluB[W-1];
        sign_r  = alu_out[W-1];
        zf_next = (alu_out == '0);
        sf_next = sign_r;
        of_next = 1'b0;
        case (alu_fun)
            FUN_ADD: of_next = (sign_a == sign_b) && (sign_r != sign_a);
            FUN_SUB: of_next = (sign_a != sign_b) && (sign_r != sign_b);
            default: of_next = 1'b0;
        endcase
        cc_next = {zf_next, sf_next, of_next};
    end

    // Stall and reset are resolved by the register priority below.
    assign cc_load = in_valid & set_cc & ~suppress_cc & ~bubble;

    // Condition uses the registered flags, never this instruction's new flags.
    always_comb begin
        zf_cur    = cc_reg[2];
        sf_cur    = cc_reg[1];
        of_cur    = cc_reg[0];
        cond_true = 1'b0;
        case (cond_fun)
            C_ALWAYS: cond_true = 1'b1;
            C_LE:     cond_true = (sf_cur ^ of_cur) | zf_cur;
            C_L:      cond_true = sf_cur ^ of_cur;
            C_E:      cond_true = zf_cur;
            C_NE:     cond_true = ~zf_cur;
            C_GE:     cond_true = ~(sf_cur ^ of_cur);
            C_G:      cond_true = ~(sf_cur ^ of_cur) & ~zf_cur;
            default:  cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            val_e_reg     <= '0;
            cnd_reg       <= 1'b0;
            cc_reg        <= CC_RESET;
        end else if (!stall) begin
            if (bubble) begin
                out_valid_reg <= 1'b0;
                val_e_reg     <= '0;
                cnd_reg       <= 1'b0;
            end else begin
                out_valid_reg <= in_valid;
                val_e_reg     <= alu_out;
                cnd_reg       <= cond_true & in_valid;
            end
            if (cc_load) begin
                cc_reg <= cc_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign valE      = val_e_reg;
    assign cnd       = cnd_reg;
    assign cc        = cc_reg;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Directed-vector bench for exec_cc_stage: the driver queues hand-computed expectations,
// and a monitor pops one per clock edge and compares the registered outputs.
module tb_exec_cc_stage;

    localparam int W = 64;
    localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [1:0]   alu_fun;
    logic [W-1:0] alu_out;
    logic         set_cc;
    logic         suppress_cc;
    logic [2:0]   cond_fun;
    logic         stall;
    logic         bubble;
    logic         out_valid;
    logic [W-1:0] valE;
    logic         cnd;
    logic [2:0]   cc;

    typedef struct {
        string        name;
        logic         ov;
        logic [W-1:0] ve;
        logic         cn;
        logic [2:0]   ccv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    exec_cc_stage #(.W(W), .CC_RESET(3'b100)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .aluA       (aluA),
        .aluB       (aluB),
        .alu_fun    (alu_fun),
        .alu_out    (alu_out),
        .set_cc     (set_cc),
        .suppress_cc(suppress_cc),
        .cond_fun   (cond_fun),
        .stall      (stall),
        .bubble     (bubble),
        .out_valid  (out_valid),
        .valE       (valE),
        .cnd        (cnd),
        .cc         (cc)
    );

    // One call = one clock edge: drive inputs, queue the expected post-edge outputs.
    task automatic step(input string nm, input logic rst, input logic stl, input logic bub,
                        input logic iv, input logic [1:0] fun, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic sc,
                        input logic sup, input logic [2:0] cf,
                        input logic e_ov, input logic [W-1:0] e_ve, input logic e_cn,
                        input logic [2:0] e_cc);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = stl; bubble = bub; in_valid = iv; alu_fun = fun;
        aluA = a; aluB = b; alu_out = r; set_cc = sc; suppress_cc = sup; cond_fun = cf;
        e.name = nm; e.ov = e_ov; e.ve = e_ve; e.cn = e_cn; e.ccv = e_cc;
        exp_q.push_back(e);
    endtask

    task automatic chk1(input string nm, input string fld, input logic [W-1:0] act,
                        input logic [W-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    endtask

    // Monitor: every edge that has a queued expectation is checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %-12s out_valid=%0b valE=%h cnd=%0b cc=%03b",
                         e.name, out_valid, valE, cnd, cc);
                chk1(e.name, "out_valid", {63'd0, out_valid}, {63'd0, e.ov});
                chk1(e.name, "valE", valE, e.ve);
                chk1(e.name, "cnd", {63'd0, cnd}, {63'd0, e.cn});
                chk1(e.name, "cc", {61'd0, cc}, {61'd0, e.ccv});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; bubble = 1'b0; in_valid = 1'b0; alu_fun = 2'd0;
        aluA = '0; aluB = '0; alu_out = '0; set_cc = 1'b0; suppress_cc = 1'b0; cond_fun = 3'd0;

        //   name           rst stl bub iv fun  aluA      aluB      alu_out   sc sup cf    ov valE      cnd cc
        step("reset0",      1, 0, 0, 0, 2'd0, 0,        0,        0,        0, 0, 3'd0, 0, 0,        0, 3'b100);
        step("reset1",      1, 0, 0, 0, 2'd0, 0,        0,        0,        0, 0, 3'd0, 0, 0,        0, 3'b100);
        step("idle_e",      0, 0, 0, 1, 2'd0, 0,        0,        0,        0, 0, 3'd3, 1, 0,        1, 3'b100);
        step("xor_4",       0, 0, 0, 1, 2'd3, 19,       23,       4,        1, 0, 3'd0, 1, 4,        1, 3'b000);
        step("xor_neg",     0, 0, 0, 1, 2'd3, -12,      -13,      7,        1, 0, 3'd3, 1, 7,        0, 3'b000);
        step("xor_zero",    0, 0, 0, 1, 2'd3, 25,       25,       0,        1, 0, 3'd4, 1, 0,        1, 3'b100);
        step("add_ovf",     0, 0, 0, 1, 2'd0, MAXP,     1,        MINN,     1, 0, 3'd3, 1, MINN,     1, 3'b011);
        step("cnd_l",       0, 0, 0, 1, 2'd0, 0,        0,        64'h10,   0, 0, 3'd2, 1, 64'h10,   0, 3'b011);
        step("cnd_ge",      0, 0, 0, 1, 2'd0, 0,        0,        64'h20,   0, 0, 3'd5, 1, 64'h20,   1, 3'b011);
        step("cnd_rsv",     0, 0, 0, 1, 2'd0, 0,        0,        64'h30,   0, 0, 3'd7, 1, 64'h30,   0, 3'b011);
        step("sub_ovf",     0, 0, 0, 1, 2'd1, 1,        MINN,     MAXP,     1, 0, 3'd6, 1, MAXP,     1, 3'b001);
        step("cnd_le",      0, 0, 0, 1, 2'd0, 0,        0,        64'h40,   0, 0, 3'd1, 1, 64'h40,   1, 3'b001);
        step("cnd_g",       0, 0, 0, 1, 2'd0, 0,        0,        64'h50,   0, 0, 3'd6, 1, 64'h50,   0, 3'b001);
        step("xor_zero2",   0, 0, 0, 1, 2'd3, 25,       25,       0,        1, 0, 3'd0, 1, 0,        1, 3'b100);
        step("stall0",      0, 1, 0, 1, 2'd0, 2,        3,        5,        1, 0, 3'd0, 1, 0,        1, 3'b100);
        step("stall1",      0, 1, 0, 1, 2'd0, 2,        3,        5,        1, 0, 3'd0, 1, 0,        1, 3'b100);
        step("bubble",      0, 0, 1, 1, 2'd0, 2,        3,        5,        1, 0, 3'd0, 0, 0,        0, 3'b100);
        step("suppress",    0, 0, 0, 1, 2'd0, ONES,     0,        ONES,     1, 1, 3'd0, 1, ONES,     1, 3'b100);
        step("invalid",     0, 0, 0, 0, 2'd0, ONES,     0,        64'h77,   1, 0, 3'd0, 0, 64'h77,   0, 3'b100);
        step("add_neg",     0, 0, 0, 1, 2'd0, ONES,     0,        ONES,     1, 0, 3'd0, 1, ONES,     1, 3'b010);
        step("reset_mid",   1, 0, 0, 1, 2'd0, ONES,     0,        ONES,     1, 0, 3'd0, 0, 0,        0, 3'b100);
        step("post_rst_e",  0, 0, 0, 1, 2'd0, 0,        0,        64'h99,   0, 0, 3'd3, 1, 64'h99,   1, 3'b100);

        @(negedge clk);
        in_valid = 1'b0; set_cc = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
